// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx
//   Serialises the PSG's stereo sample pair onto an I2S DAC link and issues
//   the one-clk next_sample strobe that starts the next PSG computation.
//
//   Frame: 32 BCK periods. The left slot is k=1..16 and the right slot is
//   k=17..31 plus k=0 of the next frame, because I2S delays data by one bit.
//   The sample pair is captured on the falling BCK edge that enters k=0.
//   next_sample pulses in that same clk. The pair is shifted out MSB-first
//   over the following frame.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous reset, active low
//   left_audio   in   [15:0] signed left sample, held by the source between pulses
//   right_audio  in   [15:0] signed right sample
//   mute         in   zero the captured frame (only with AUDIO_I2S_MUTE_EN)
//   next_sample  out  one-clk request for the next sample pair
//   i2s_bck      out  bit clock, clk / (2*CLK_DIV)
//   i2s_lrck     out  word select, 0 = left slot, 1 = right slot
//   i2s_data     out  serial data, changes only on BCK falling edges
//
// Parameters
//   CLK_DIV      clk cycles per BCK half-period (>= 1)
//
// Configuration
//   AUDIO_I2S_MUTE_EN  adds the mute input. When mute is high at the k=0 capture,
//                      the whole following frame is zeros.

module audio_i2s_tx #(
  parameter int CLK_DIV = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] left_audio,
  input  logic [15:0] right_audio,
`ifdef AUDIO_I2S_MUTE_EN
  input  logic        mute,
`endif
  output logic        next_sample,
  output logic        i2s_bck,
  output logic        i2s_lrck,
  output logic        i2s_data
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       bit_cnt;
  logic [31:0]      sr;

  logic        div_wrap;   // bck toggles in this clk
  logic        fe;         // this toggle is a falling edge
  logic [4:0]  bit_nxt;    // slot index entered on this falling edge
  logic [31:0] load_word;  // word captured when entering k=0

  always_comb begin
    div_wrap = (div_cnt == DIV_LAST);
    fe       = div_wrap & i2s_bck;
    bit_nxt  = bit_cnt + 5'd1;  // 31 wraps to 0 naturally
`ifdef AUDIO_I2S_MUTE_EN
    load_word = mute ? 32'h0 : {left_audio, right_audio};
`else
    load_word = {left_audio, right_audio};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      i2s_bck     <= 1'b0;
      bit_cnt     <= 5'd31;   // the first falling edge then enters k=0
      i2s_lrck    <= 1'b1;
      sr          <= 32'h0;
      i2s_data    <= 1'b0;
      next_sample <= 1'b0;
    end else begin
      next_sample <= 1'b0;
      if (div_wrap) begin
        div_cnt <= '0;
        i2s_bck <= ~i2s_bck;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      // Only falling edges move the frame state. Rising edges just toggle bck.
      if (fe) begin
        bit_cnt  <= bit_nxt;
        i2s_data <= sr[31];
        i2s_lrck <= bit_nxt[4];   // k >= 16
        if (bit_nxt == 5'd0) begin
          // The previous frame's right LSB leaves via sr[31] in the same clk.
          sr          <= load_word;
          next_sample <= 1'b1;
        end else begin
          sr <= {sr[30:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_i2s_tx.sv
module tb_audio_i2s_tx;

  localparam int CLK_DIV = 8;
`ifdef AUDIO_I2S_MUTE_EN
  localparam bit MUTE_EN = 1'b1;
`else
  localparam bit MUTE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] left_audio, right_audio;
  logic        mute;
  logic        next_sample, i2s_bck, i2s_lrck, i2s_data;

  always #5 clk = ~clk;

  audio_i2s_tx #(.CLK_DIV(CLK_DIV)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .left_audio  (left_audio),
    .right_audio (right_audio),
`ifdef AUDIO_I2S_MUTE_EN
    .mute        (mute),
`endif
    .next_sample (next_sample),
    .i2s_bck     (i2s_bck),
    .i2s_lrck    (i2s_lrck),
    .i2s_data    (i2s_data)
  );

  typedef struct {
    logic [15:0] left;
    logic [15:0] right;
    bit          mute;
    bit          poke;   // disturb left_audio mid-frame
    logic [31:0] exp;    // expected serial word (unmuted)
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // bench-side observation state, sampled at negedge
  int   cyc, last_ns, ns_period, last_rise, bck_period, ns_total, k_tb;
  logic prev_bck;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sync_reset_state();
    cyc = 0; last_ns = -1; ns_period = -1; last_rise = -1; bck_period = -1;
    prev_bck = 1'b0; k_tb = 31;
  endtask

  // Advance to the next BCK falling edge, observing every negedge on the way.
  task automatic fe_step(output logic d, output logic lr);
    int  n;
    bit  got;
    n = 0; got = 0;
    while (!got && n < 4*CLK_DIV) begin
      @(negedge clk);
      cyc++; n++;
      if (!prev_bck && i2s_bck) begin
        if (last_rise >= 0) bck_period = cyc - last_rise;
        last_rise = cyc;
      end
      if (next_sample) begin
        ns_total++;
        if (last_ns >= 0) ns_period = cyc - last_ns;
        last_ns = cyc;
      end
      if (prev_bck && !i2s_bck) got = 1;
      prev_bck = i2s_bck;
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL fe_timeout: got no falling edge in %0d clk expected one", n);
    end
    k_tb = (k_tb + 1) % 32;
    d  = i2s_data;
    lr = i2s_lrck;
  endtask

  // Collect k=1..31 and the following k=0 into a word, MSB first.
  task automatic collect_frame(output logic [31:0] word, output logic [31:0] lrs,
                               input bit poke, input logic [15:0] restore_left);
    logic d, lr;
    word = '0; lrs = '0;
    for (int j = 1; j <= 32; j++) begin
      fe_step(d, lr);
      word[32-j] = d;
      lrs[32-j]  = lr;
      if (poke && j == 5)  left_audio = ~restore_left;
      if (poke && j == 20) left_audio = restore_left;
    end
  endtask

  initial begin
    vec_t        vecs[5];
    logic [31:0] word, lrs, exp;
    logic        d, lr;
    int          ns0;

    vecs[0] = '{16'h8001, 16'h1234, 1'b0, 1'b0, 32'h8001_1234};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b0, 1'b0, 32'hFFFF_0000};
    vecs[2] = '{16'h7FFF, 16'h8000, 1'b0, 1'b1, 32'h7FFF_8000};
    vecs[3] = '{16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 32'hA5A5_5A5A};
    vecs[4] = '{16'h0001, 16'hFFFE, 1'b0, 1'b0, 32'h0001_FFFE};

    ns_total = 0;
    sync_reset_state();
    rst_n = 1'b0;
    left_audio  = vecs[0].left;
    right_audio = vecs[0].right;
    mute        = vecs[0].mute;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_bck",  {31'd0, i2s_bck},     32'd0);
    check("rst_lrck", {31'd0, i2s_lrck},    32'd1);
    check("rst_data", {31'd0, i2s_data},    32'd0);
    check("rst_ns",   {31'd0, next_sample}, 32'd0);

    // release; first falling edge enters k=0 at clk 2*CLK_DIV
    rst_n = 1'b1;
    sync_reset_state();
    fe_step(d, lr);
    check("first_ns_clk", last_ns, 2*CLK_DIV);
    check("first_data",   {31'd0, d},  32'd0);
    check("first_lrck",   {31'd0, lr}, 32'd0);

    // table-driven frames; vec i was captured at the k=0 just passed
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        left_audio  = vecs[i+1].left;
        right_audio = vecs[i+1].right;
        mute        = vecs[i+1].mute;
      end else begin
        mute = 1'b0;
      end
      ns0 = ns_total;
      collect_frame(word, lrs, vecs[i].poke, left_audio);
      exp = (MUTE_EN && vecs[i].mute) ? 32'h0 : vecs[i].exp;
      check($sformatf("stream[%0d]", i), word, exp);
      check($sformatf("lrck[%0d]", i),   lrs,  32'h0001_FFFE);
      check($sformatf("ns_count[%0d]", i), ns_total - ns0, 1);
      check($sformatf("ns_period[%0d]", i), ns_period, 64*CLK_DIV);
      check($sformatf("bck_period[%0d]", i), bck_period, 2*CLK_DIV);
    end

    // mid-frame reset at k=20, asserted between clock edges
    left_audio  = 16'hC3C3;
    right_audio = 16'h3C3C;
    for (int s = 0; s < 40 && k_tb != 20; s++) fe_step(d, lr);
    check("k_reached_20", k_tb, 20);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_bck",  {31'd0, i2s_bck},     32'd0);
    check("mid_rst_lrck", {31'd0, i2s_lrck},    32'd1);
    check("mid_rst_data", {31'd0, i2s_data},    32'd0);
    check("mid_rst_ns",   {31'd0, next_sample}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sync_reset_state();
    fe_step(d, lr);
    check("restart_ns_clk", last_ns, 2*CLK_DIV);
    check("restart_data",   {31'd0, d}, 32'd0);
    collect_frame(word, lrs, 1'b0, left_audio);
    check("restart_stream", word, 32'hC3C3_3C3C);
    check("restart_lrck",   lrs,  32'h0001_FFFE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
